// File: rtl/register_file_pkg.sv
// Shared definitions for the register file: default width, FunSel codes and read-select codes.
package register_file_pkg;

    localparam int DATA_W_DEFAULT = 32;

    typedef enum logic [2:0] {
        FS_DEC    = 3'b000,
        FS_INC    = 3'b001,
        FS_LOAD   = 3'b010,
        FS_CLR    = 3'b011,
        FS_LD8    = 3'b100,
        FS_LD16   = 3'b101,
        FS_SHL8   = 3'b110,
        FS_SEXT16 = 3'b111
    } fun_sel_e;

    localparam logic [2:0] SEL_R1 = 3'b000;
    localparam logic [2:0] SEL_R2 = 3'b001;
    localparam logic [2:0] SEL_R3 = 3'b010;
    localparam logic [2:0] SEL_R4 = 3'b011;
    localparam logic [2:0] SEL_S1 = 3'b100;
    localparam logic [2:0] SEL_S2 = 3'b101;
    localparam logic [2:0] SEL_S3 = 3'b110;
    localparam logic [2:0] SEL_S4 = 3'b111;

endpackage

// File: rtl/register_file_gp_register.sv
// One register of the file with its FunSel-selected update function.
// Build option: REGISTER_FILE_SATURATE_EN makes increment/decrement saturate instead of wrap.
module gp_register
    import register_file_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              E,
    input  logic [2:0]        FunSel,
    input  logic [DATA_W-1:0] I,
    output logic [DATA_W-1:0] Q
);

    localparam logic [DATA_W-1:0] ONE      = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] ALL_ONES = '1;

    logic [DATA_W-1:0] q_q;
    logic [DATA_W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (E) begin
            case (FunSel)
`ifdef REGISTER_FILE_SATURATE_EN
                FS_DEC:    q_d = (q_q == '0) ? q_q : q_q - ONE;
                FS_INC:    q_d = (q_q == ALL_ONES) ? q_q : q_q + ONE;
`else
                FS_DEC:    q_d = q_q - ONE;
                FS_INC:    q_d = q_q + ONE;
`endif
                FS_LOAD:   q_d = I;
                FS_CLR:    q_d = '0;
                FS_LD8:    q_d = {{(DATA_W-8){1'b0}}, I[7:0]};
                FS_LD16:   q_d = {{(DATA_W-16){1'b0}}, I[15:0]};
                FS_SHL8:   q_d = {q_q[DATA_W-9:0], I[7:0]};
                FS_SEXT16: q_d = {{(DATA_W-16){I[15]}}, I[15:0]};
                default:   q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q = q_q;

endmodule

// File: rtl/register_file.sv
// Eight-entry register file (R1..R4, S1..S4) feeding the ALU operand ports OutA/OutB.
// Build option: REGISTER_FILE_SATURATE_EN selects saturating increment/decrement in every register.
module register_file
    import register_file_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [DATA_W-1:0] I,
    input  logic [2:0]        FunSel,
    input  logic [3:0]        RegSel,
    input  logic [3:0]        ScrSel,
    input  logic [2:0]        OutASel,
    input  logic [2:0]        OutBSel,
    output logic [DATA_W-1:0] OutA,
    output logic [DATA_W-1:0] OutB
);

    // Index 0..3 = R1..R4, 4..7 = S1..S4; the select buses list R1/S1 in their MSB.
    logic [7:0]        enable_vec;
    logic [DATA_W-1:0] reg_val [8];

    assign enable_vec = {RegSel, ScrSel};

    for (genvar g = 0; g < 8; g++) begin : g_regs
        gp_register #(
            .DATA_W (DATA_W)
        ) u_reg (
            .Clock  (Clock),
            .Reset  (Reset),
            .E      (enable_vec[7-g]),
            .FunSel (FunSel),
            .I      (I),
            .Q      (reg_val[g])
        );
    end

    always_comb begin
        OutA = '0;
        case (OutASel)
            SEL_R1:  OutA = reg_val[0];
            SEL_R2:  OutA = reg_val[1];
            SEL_R3:  OutA = reg_val[2];
            SEL_R4:  OutA = reg_val[3];
            SEL_S1:  OutA = reg_val[4];
            SEL_S2:  OutA = reg_val[5];
            SEL_S3:  OutA = reg_val[6];
            SEL_S4:  OutA = reg_val[7];
            default: OutA = '0;
        endcase
    end

    always_comb begin
        OutB = '0;
        case (OutBSel)
            SEL_R1:  OutB = reg_val[0];
            SEL_R2:  OutB = reg_val[1];
            SEL_R3:  OutB = reg_val[2];
            SEL_R4:  OutB = reg_val[3];
            SEL_S1:  OutB = reg_val[4];
            SEL_S2:  OutB = reg_val[5];
            SEL_S3:  OutB = reg_val[6];
            SEL_S4:  OutB = reg_val[7];
            default: OutB = '0;
        endcase
    end

endmodule

// File: tb/tb_register_file.sv
// Randomized self-checking bench for register_file against a behavioural model of the 8 registers.
`timescale 1ns/1ps
module tb_register_file;

    logic        Clock;
    logic        Reset;
    logic [31:0] I;
    logic [2:0]  FunSel;
    logic [3:0]  RegSel;
    logic [3:0]  ScrSel;
    logic [2:0]  OutASel;
    logic [2:0]  OutBSel;
    logic [31:0] OutA;
    logic [31:0] OutB;

    int total;
    int bad;

    // model[0..3] = R1..R4, model[4..7] = S1..S4
    logic [31:0] model [8];

    register_file dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .I       (I),
        .FunSel  (FunSel),
        .RegSel  (RegSel),
        .ScrSel  (ScrSel),
        .OutASel (OutASel),
        .OutBSel (OutBSel),
        .OutA    (OutA),
        .OutB    (OutB)
    );

    initial Clock = 1'b0;
    always #10 Clock = ~Clock;

    function automatic logic [31:0] ref_next(input logic [2:0] fs, input logic [31:0] q, input logic [31:0] d);
        logic [31:0] r;
        case (fs)
            3'd0: begin
`ifdef REGISTER_FILE_SATURATE_EN
                r = (q == 32'd0) ? 32'd0 : q - 32'd1;
`else
                r = q - 32'd1;
`endif
            end
            3'd1: begin
`ifdef REGISTER_FILE_SATURATE_EN
                r = (q == 32'hFFFFFFFF) ? q : q + 32'd1;
`else
                r = q + 32'd1;
`endif
            end
            3'd2: r = d;
            3'd3: r = 32'd0;
            3'd4: r = d % 256;
            3'd5: r = d % 65536;
            3'd6: r = (q * 256) + (d % 256);
            default: r = (d % 65536 >= 32768) ? (32'hFFFF0000 + d % 65536) : d % 65536;
        endcase
        return r;
    endfunction

    function automatic bit enabled(input int idx, input logic [3:0] rs, input logic [3:0] ss);
        if (idx < 4) return rs[3-idx];
        return ss[7-idx];
    endfunction

    // Applies one rising edge, advancing the model from the inputs in effect at that edge.
    task automatic tick();
        logic [31:0] nxt [8];
        for (int k = 0; k < 8; k++)
            nxt[k] = enabled(k, RegSel, ScrSel) ? ref_next(FunSel, model[k], I) : model[k];
        @(posedge Clock);
        #1;
        for (int k = 0; k < 8; k++) model[k] = nxt[k];
    endtask

    task automatic drive(input logic [3:0] rs, input logic [3:0] ss, input logic [2:0] fs, input logic [31:0] d);
        RegSel = rs;
        ScrSel = ss;
        FunSel = fs;
        I      = d;
    endtask

    task automatic test_reset();
        Reset   = 1'b0;
        I       = $urandom;
        FunSel  = 3'($urandom);
        RegSel  = 4'($urandom);
        ScrSel  = 4'($urandom);
        for (int k = 0; k < 8; k++) model[k] = 32'd0;
        #2;
        for (int k = 0; k < 8; k++) begin
            OutASel = 3'(k);
            OutBSel = 3'(7 - k);
            #1;
            total++;
            if (OutA !== 32'd0 || OutB !== 32'd0) begin
                bad++;
                $display("[TB] FAIL reset_sel%0d: OutA=%h OutB=%h want 00000000", k, OutA, OutB);
            end
        end
        @(posedge Clock);
        #1;
        total++;
        if (OutA !== 32'd0) begin
            bad++;
            $display("[TB] FAIL reset_held_edge: OutA=%h want 00000000", OutA);
        end
        @(negedge Clock);
        drive(4'b0000, 4'b0000, 3'b010, 32'd0);
        Reset = 1'b1;
        @(posedge Clock);
        #1;
    endtask

    task automatic test_load();
        drive(4'b1000, 4'b0000, 3'b010, 32'h12341234);
        tick();
        OutASel = 3'b000;
        OutBSel = 3'b001;
        #1;
        total++;
        if (OutA !== 32'h12341234) begin
            bad++;
            $display("[TB] FAIL load_r1: OutA=%h want 12341234", OutA);
        end
        total++;
        if (OutB !== 32'h00000000) begin
            bad++;
            $display("[TB] FAIL load_r2_untouched: OutB=%h want 00000000", OutB);
        end
    endtask

    task automatic test_inc_dec_bounds();
        logic [31:0] exp_inc;
        logic [31:0] exp_dec;
`ifdef REGISTER_FILE_SATURATE_EN
        exp_inc = 32'hFFFFFFFF;
        exp_dec = 32'h00000000;
`else
        exp_inc = 32'h00000000;
        exp_dec = 32'hFFFFFFFF;
`endif
        drive(4'b0100, 4'b0000, 3'b010, 32'hFFFFFFFF);
        tick();
        drive(4'b0100, 4'b0000, 3'b001, $urandom);
        tick();
        drive(4'b0010, 4'b0000, 3'b000, $urandom);
        tick();
        OutASel = 3'b001;
        OutBSel = 3'b010;
        #1;
        total++;
        if (OutA !== exp_inc) begin
            bad++;
            $display("[TB] FAIL inc_top: OutA=%h want %h", OutA, exp_inc);
        end
        total++;
        if (OutB !== exp_dec) begin
            bad++;
            $display("[TB] FAIL dec_zero: OutB=%h want %h", OutB, exp_dec);
        end
    endtask

    task automatic test_shift_sext();
        drive(4'b0000, 4'b1000, 3'b100, 32'hFFFFFFAB);
        tick();
        drive(4'b0000, 4'b1000, 3'b110, 32'h000000CD);
        tick();
        tick();
        OutASel = 3'b100;
        OutBSel = 3'b100;
        #1;
        total++;
        if (OutA !== 32'h00ABCDCD || OutB !== 32'h00ABCDCD) begin
            bad++;
            $display("[TB] FAIL shift_in: OutA=%h OutB=%h want 00ABCDCD", OutA, OutB);
        end
        drive(4'b0000, 4'b1000, 3'b111, 32'h00008001);
        tick();
        #1;
        total++;
        if (OutA !== 32'hFFFF8001) begin
            bad++;
            $display("[TB] FAIL sext16: OutA=%h want FFFF8001", OutA);
        end
        drive(4'b0000, 4'b0100, 3'b101, 32'hABCD8001);
        tick();
        OutBSel = 3'b101;
        #1;
        total++;
        if (OutB !== 32'h00008001) begin
            bad++;
            $display("[TB] FAIL ld16: OutB=%h want 00008001", OutB);
        end
    endtask

    task automatic test_clear_all();
        drive(4'b1111, 4'b1111, 3'b010, $urandom | 32'h1);
        tick();
        drive(4'b1111, 4'b1111, 3'b011, $urandom);
        tick();
        for (int k = 0; k < 8; k++) begin
            OutASel = 3'(k);
            #1;
            total++;
            if (OutA !== 32'd0) begin
                bad++;
                $display("[TB] FAIL clear_all_sel%0d: OutA=%h want 00000000", k, OutA);
            end
        end
        drive(4'b0000, 4'b0000, 3'b001, $urandom);
        tick();
        for (int k = 0; k < 8; k++) begin
            OutBSel = 3'(k);
            #1;
            total++;
            if (OutB !== 32'd0) begin
                bad++;
                $display("[TB] FAIL no_enable_sel%0d: OutB=%h want 00000000", k, OutB);
            end
        end
    endtask

    task automatic test_reset_midcycle();
        drive(4'b0010, 4'b0000, 3'b010, 32'h55555555);
        tick();
        drive(4'b0010, 4'b0000, 3'b001, 32'd0);
        OutASel = 3'b010;
        OutBSel = 3'b010;
        #1;
        total++;
        if (OutA !== 32'h55555555) begin
            bad++;
            $display("[TB] FAIL pre_reset_r3: OutA=%h want 55555555", OutA);
        end
        #2;
        Reset = 1'b0;
        for (int k = 0; k < 8; k++) model[k] = 32'd0;
        #1;
        total++;
        if (OutA !== 32'd0) begin
            bad++;
            $display("[TB] FAIL async_reset_r3: OutA=%h want 00000000", OutA);
        end
        #1;
        Reset = 1'b1;
        tick();
        total++;
        if (OutA !== 32'h00000001) begin
            bad++;
            $display("[TB] FAIL post_reset_inc: OutA=%h want 00000001", OutA);
        end
    endtask

    task automatic test_random();
        logic [31:0] d;
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 3))
                0: d = 32'hFFFFFFFF;
                1: d = 32'h0000FF80 | ($urandom & 32'hFFFF00FF);
                default: d = $urandom;
            endcase
            drive(4'($urandom), 4'($urandom), 3'($urandom), d);
            if ($urandom_range(0, 9) == 0) begin
                RegSel = 4'b0000;
                ScrSel = 4'b0000;
            end
            tick();
            OutASel = 3'($urandom);
            OutBSel = ($urandom_range(0, 4) == 0) ? OutASel : 3'($urandom);
            #1;
            total++;
            if (OutA !== model[OutASel] || OutB !== model[OutBSel]) begin
                bad++;
                $display("[TB] FAIL random_%0d: OutA[%0d]=%h want %h OutB[%0d]=%h want %h",
                         n, OutASel, OutA, model[OutASel], OutBSel, OutB, model[OutBSel]);
            end
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        OutASel = 3'b000;
        OutBSel = 3'b000;
        test_reset();
        test_load();
        test_inc_dec_bounds();
        test_shift_sext();
        test_clear_all();
        test_reset_midcycle();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
